// File: rtl/instr_loader.sv
// instr_loader
//   Write side of the 9-bit instruction store. Receives a program image over a
//   byte stream (length, word records, XOR checksum), writes each word into the
//   instruction memory and keeps the CPU stalled until a complete image with a
//   matching checksum has been written.
//
//   Image: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N records
//   of {LO = bits 7:0, HI = bit 8 in HI[0], HI[7:1] must be 0}, then CSUM =
//   XOR of all record bytes (length bytes excluded).
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     single-cycle pulse, begins a load session (IDLE/DONE/ERR only)
//   rx_data   incoming byte
//   rx_valid  rx_data valid
//   rx_ready  loader accepts a byte this cycle (registered)
//   wr_en     instruction memory write strobe
//   wr_addr   write address (D bits)
//   wr_data   write data, 9-bit machine word
//   cpu_hold  stalls CPU / program counter while high
//   done      load finished, checksum matched (level)
//   error     load aborted (level)
module instr_loader #(
  parameter int unsigned D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [8:0]   wr_data,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  data_lo;
  logic [7:0]  csum;
  // One bit wider than the address so that N == 2**D is representable.
  logic [D:0]  idx;

  logic        accept;
  logic [15:0] n_rx;
  logic        n_bad;
  logic        last_word;

  always_comb begin
    accept    = rx_valid && rx_ready;
    n_rx      = {rx_data, len_lo};
    n_bad     = (n_rx == 16'd0) || ({16'd0, n_rx} > (32'd1 << D));
    last_word = (32'(idx) == (32'(len) - 32'd1));
  end

  // rx_ready is registered, so every transition into a byte-accepting state
  // raises it and every transition out of one lowers it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      len_lo   <= '0;
      len      <= '0;
      data_lo  <= '0;
      csum     <= '0;
      idx      <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN_LO;
            rx_ready <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            idx      <= '0;
            csum     <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len <= n_rx;
            if (n_bad) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state <= DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (accept) begin
            data_lo <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= DATA_HI;
          end
        end
        DATA_HI: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            rx_ready <= 1'b0;
            if (rx_data[7:1] != 7'd0) begin
              state    <= ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state   <= WRITE;
              wr_en   <= 1'b1;
              wr_addr <= idx[D-1:0];
              wr_data <= {rx_data[0], data_lo};
            end
          end
        end
        WRITE: begin
          idx      <= idx + (D+1)'(1);
          rx_ready <= 1'b1;
          state    <= last_word ? CSUM : DATA_LO;
        end
        CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader
//   Directed bench for instr_loader (D = 12). A negedge monitor logs every
//   write and flags back-to-back strobes or rx_ready high during a write.
module tb_instr_loader;

  localparam int unsigned D = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [8:0]   wr_data;
  logic         cpu_hold;
  logic         done;
  logic         error;

  int asserts = 0;
  int failures = 0;

  logic [D-1:0] log_addr[$];
  logic [8:0]   log_data[$];
  int           wr_consec = 0;
  int           ready_in_write = 0;
  logic         prev_wr = 1'b0;
  logic         bp_mode = 1'b0;

  instr_loader #(.D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      if (prev_wr) wr_consec++;
      if (rx_ready) ready_in_write++;
    end
    prev_wr = wr_en;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    wr_consec = 0;
    ready_in_write = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Presents one byte until accepted. In bp_mode rx_valid toggles randomly.
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic taken;
    n = 0;
    taken = 1'b0;
    @(negedge clk);
    rx_data = b;
    while (!taken && n < 200) begin
      rx_valid = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rx_valid && rx_ready) begin
        @(posedge clk);
        taken = 1'b1;
        #1 rx_valid = 1'b0;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    rx_valid = 1'b0;
    if (!taken) begin
      asserts++;
      failures++;
      $display("FAIL byte_accept_timeout: byte %02h not accepted, required accept within 200 cycles", b);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    asserts++;
    if ({rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !==
        {1'b0, 1'b0, 12'h000, 9'h000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b, required 0 0 000 000 1 0 0",
               rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
    end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h7E); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h01);
    send_byte(8'h4C);
    settle();
    asserts++;
    if (log_addr.size() != 2) begin
      failures++;
      $display("FAIL basic_write_count: got %0d, required 2", log_addr.size());
    end else begin
      asserts++;
      if ({log_addr[0], log_data[0], log_addr[1], log_data[1]} !== {12'h000, 9'h07E, 12'h001, 9'h133}) begin
        failures++;
        $display("FAIL basic_writes: got (%h,%h) (%h,%h), required (000,07e) (001,133)",
                 log_addr[0], log_data[0], log_addr[1], log_data[1]);
      end
    end
    asserts++;
    if ({done, cpu_hold, error} !== 3'b100) begin
      failures++;
      $display("FAIL basic_status: done/hold/err=%b%b%b, required 100", done, cpu_hold, error);
    end
  endtask

  task automatic test_bad_csum();
    clear_log();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h7E); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h01);
    send_byte(8'h4D);
    settle();
    asserts++;
    if (log_addr.size() != 2) begin
      failures++;
      $display("FAIL badcsum_write_count: got %0d, required 2", log_addr.size());
    end
    asserts++;
    if ({done, cpu_hold, error} !== 3'b011) begin
      failures++;
      $display("FAIL badcsum_status: done/hold/err=%b%b%b, required 011", done, cpu_hold, error);
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] cs;
    logic [8:0] w;
    int bad;
    // N = 0
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    settle();
    asserts++;
    if ({error, cpu_hold, done, rx_ready} !== 4'b1100 || log_addr.size() != 0) begin
      failures++;
      $display("FAIL len_zero: err/hold/done/rdy=%b%b%b%b writes=%0d, required 1100 writes=0",
               error, cpu_hold, done, rx_ready, log_addr.size());
    end
    // N = 4097
    pulse_start();
    send_byte(8'h01); send_byte(8'h10);
    settle();
    asserts++;
    if ({error, done} !== 2'b10 || log_addr.size() != 0) begin
      failures++;
      $display("FAIL len_4097: err/done=%b%b writes=%0d, required 10 writes=0", error, done, log_addr.size());
    end
    // N = 4096, full memory
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h10);
    cs = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      w = 9'((i * 37 + 5) & 9'h1FF);
      cs = cs ^ w[7:0] ^ {7'd0, w[8]};
      send_byte(w[7:0]);
      send_byte({7'd0, w[8]});
    end
    send_byte(cs);
    settle();
    asserts++;
    if (log_addr.size() != 4096) begin
      failures++;
      $display("FAIL len_4096_count: got %0d, required 4096", log_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
        w = 9'((i * 37 + 5) & 9'h1FF);
        if (log_addr[i] !== 12'(i) || log_data[i] !== w) bad++;
      end
      asserts++;
      if (bad != 0) begin
        failures++;
        $display("FAIL len_4096_data: %0d wrong entries, required 0", bad);
      end
      asserts++;
      if (log_addr[4095] !== 12'hFFF) begin
        failures++;
        $display("FAIL len_4096_last_addr: got %h, required fff", log_addr[4095]);
      end
    end
    asserts++;
    if ({done, cpu_hold, error} !== 3'b100) begin
      failures++;
      $display("FAIL len_4096_status: done/hold/err=%b%b%b, required 100", done, cpu_hold, error);
    end
  endtask

  task automatic test_bad_hi();
    clear_log();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h02);
    settle();
    asserts++;
    if (log_addr.size() != 1 || log_data[0] !== 9'h011) begin
      failures++;
      $display("FAIL bad_hi_writes: count=%0d, required 1 write of 011", log_addr.size());
    end
    asserts++;
    if ({done, cpu_hold, error} !== 3'b011) begin
      failures++;
      $display("FAIL bad_hi_status: done/hold/err=%b%b%b, required 011", done, cpu_hold, error);
    end
  endtask

  // Three words under random rx_valid, with a stray start mid-load.
  task automatic test_back_to_back();
    clear_log();
    bp_mode = 1'b1;
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h01);
    pulse_start();
    send_byte(8'h5A); send_byte(8'h00);
    send_byte(8'hC3); send_byte(8'h01);
    // A5^01^5A^00^C3^01 = 3C
    send_byte(8'h3C);
    bp_mode = 1'b0;
    settle();
    asserts++;
    if (log_addr.size() != 3) begin
      failures++;
      $display("FAIL bp_write_count: got %0d, required 3", log_addr.size());
    end else begin
      asserts++;
      if ({log_addr[0], log_data[0], log_addr[1], log_data[1], log_addr[2], log_data[2]} !==
          {12'h000, 9'h1A5, 12'h001, 9'h05A, 12'h002, 9'h1C3}) begin
        failures++;
        $display("FAIL bp_writes: got (%h,%h) (%h,%h) (%h,%h), required (000,1a5) (001,05a) (002,1c3)",
                 log_addr[0], log_data[0], log_addr[1], log_data[1], log_addr[2], log_data[2]);
      end
    end
    asserts++;
    if (ready_in_write != 0 || wr_consec != 0) begin
      failures++;
      $display("FAIL bp_write_cycles: ready_in_write=%0d consecutive_wr=%0d, required 0 0", ready_in_write, wr_consec);
    end
    asserts++;
    if ({done, cpu_hold, error} !== 3'b100) begin
      failures++;
      $display("FAIL bp_status: done/hold/err=%b%b%b, required 100", done, cpu_hold, error);
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h55); send_byte(8'h01);
    settle();
    do_reset();
    asserts++;
    if ({cpu_hold, done, error, rx_ready} !== 4'b1000 || log_addr.size() != 1) begin
      failures++;
      $display("FAIL midload_reset: hold/done/err/rdy=%b%b%b%b writes=%0d, required 1000 writes=1",
               cpu_hold, done, error, rx_ready, log_addr.size());
    end
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h12); send_byte(8'h01);
    send_byte(8'h13);
    settle();
    asserts++;
    if ({done, cpu_hold, error} !== 3'b100 || log_addr.size() != 1 || log_data[0] !== 9'h112) begin
      failures++;
      $display("FAIL midload_reload: done/hold/err=%b%b%b writes=%0d, required 100 writes=1 data=112",
               done, cpu_hold, error, log_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_len_bounds();
    test_bad_hi();
    test_back_to_back();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Loads a program image into the 9-bit-wide instruction memory over a byte stream.
- It is the write side of the instruction store: it writes words that the program counter later reads.
- It sits between the host byte link (UART/testbench FIFO) and the instruction memory write port.
- It holds the CPU in a stall state until a complete, checksummed image has been written.

Parameters:
- D, 12, instruction address width; memory depth is 2**D words.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load session.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  D  write address.
- wr_data  output  9  write data (machine code word).
- cpu_hold  output  1  stalls the CPU and program counter while high.
- done  output  1  load finished and checksum matched (level).
- error  output  1  load aborted (level).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. The CPU stays held after reset until a load succeeds.
- Byte transfer: a byte is accepted on a cycle where rx_valid && rx_ready. rx_ready is a registered output and is high only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM. Bytes presented outside those states are not consumed.
- Image format, in order:
  - LEN_LO, LEN_HI: a 16-bit word count N, little-endian.
  - N word records, each two bytes: LO = bits 7:0, then HI = bit 8 in HI[0]. HI[7:1] must be 0.
  - CSUM: XOR of every record byte. The length bytes are excluded.
- States:
  - IDLE: on start -> LEN_LO; clear done, error, word counter, checksum; set cpu_hold=1.
  - LEN_LO: on accept -> LEN_HI; latch low byte.
  - LEN_HI: on accept, evaluate N. If N==0 or N>2**D -> ERR; else -> DATA_LO.
  - DATA_LO: on accept -> DATA_HI; latch byte; fold it into the checksum.
  - DATA_HI: on accept, fold the byte into the checksum. If HI[7:1]!=0 -> ERR; else -> WRITE.
  - WRITE: one cycle with wr_en=1, wr_addr=index, wr_data={HI[0],LO}, rx_ready=0. Then increment index. If index==N-1 -> CSUM, else -> DATA_LO.
  - CSUM: on accept, compare the byte to the running XOR. Match -> DONE; mismatch -> ERR.
  - DONE: done=1, cpu_hold=0. start -> LEN_LO.
  - ERR: error=1, cpu_hold=1. start -> LEN_LO.
- Latency: wr_en rises on the cycle after the HI byte is accepted. done and cpu_hold=0 appear on the cycle after the checksum byte is accepted.
- Address and counter widths: the word index is D+1 bits so that N=2**D is legal. wr_addr is the low D bits. The last address written is 2**D-1, with no wrap.
- Words already written before an error are not rolled back.
- start while in LEN_LO..CSUM is ignored; the load continues.
- reset mid-load returns to IDLE with cpu_hold=1. A partially written image remains in memory.
- start together with reset: reset wins.
- rx_valid may drop at any time; the FSM waits in its current state indefinitely. There is no timeout.
- wr_en is never high in two consecutive cycles.

Test Plan:
- Basic 2-word load: start; bytes 02,00, 7E,00, 33,01, checksum 7E^00^33^01=4C -> writes (0,0x07E), (1,0x133); done=1; cpu_hold=0; error=0.
- Bad checksum: same image but checksum 4D -> both writes occur, then error=1, cpu_hold=1, done=0.
- Length bounds: N=0 (00,00) -> error=1 after LEN_HI with no writes. N=4097 (01,10) with D=12 -> error. N=4096 loads fully; last wr_addr=0xFFF.
- Illegal HI byte: record LO=FF, HI=02 -> no write for that word; error=1.
- Backpressure: toggle rx_valid randomly during a 3-word load -> each byte consumed exactly once; writes in order to 0,1,2; rx_ready=0 in every WRITE cycle.
- Reset mid-load after 1 word: IDLE; cpu_hold=1; done=0. A following start plus a full valid image gives done=1.
